// File: rtl/zero_scan_ctrl.sv
// ---------------------------------------------------------------------------
// zero_scan_ctrl
//
// Scans a latched WIDTH-bit word one bit per cycle, LSB first, and counts
// non-overlapping runs of RUN consecutive zeros. Each completed run gives a
// one-cycle registered hit pulse and increments hit_count.
//
// Ports
//   clk       : sole clock, rising edge
//   reset     : asynchronous, active-low reset
//   start     : begin a scan of data_in (accepted only in IDLE)
//   data_in   : word to scan, latched on an accepted start
//   abort     : cancel an in-progress scan (only meaningful in SHIFT)
//   busy      : high while bits are being consumed
//   done      : one-cycle pulse when a scan completes
//   hit       : one-cycle pulse per detected zero run
//   hit_count : hits in the current or most recent scan
//   irq_clr   : (ZERO_SCAN_IRQ_EN only) clears the sticky irq
//   irq       : (ZERO_SCAN_IRQ_EN only) sticky flag, set after a scan with hits
//
// Optional feature macro: ZERO_SCAN_IRQ_EN
// ---------------------------------------------------------------------------
module zero_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int RUN   = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         abort,
`ifdef ZERO_SCAN_IRQ_EN
    input  logic                         irq_clr,
    output logic                         irq,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         hit,
    output logic [$clog2(WIDTH+1)-1:0]   hit_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = $clog2(RUN + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [RW-1:0] RUN_M1   = RW'(RUN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [IW-1:0]     idx_q,   idx_d;
    logic [RW-1:0]     run_q,   run_d;
    logic              hit_q,   hit_d;
    logic [CW-1:0]     cnt_q,   cnt_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // start takes priority over abort here; abort is ignored in IDLE
                if (start) begin
                    data_d  = data_in;
                    idx_d   = '0;
                    run_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    // Drop the scan: no done, and the hit that this cycle's
                    // bit might have produced stays suppressed (hit_d = 0).
                    state_d = IDLE;
                    idx_d   = '0;
                    run_d   = '0;
                    cnt_d   = '0;
                end else begin
                    if (!data_q[idx_q]) begin
                        // Run completes on this zero: pulse next cycle and
                        // restart counting so runs never overlap.
                        if (run_q == RUN_M1) begin
                            hit_d = 1'b1;
                            cnt_d = cnt_q + CW'(1);
                            run_d = '0;
                        end else begin
                            run_d = run_q + RW'(1);
                        end
                    end else begin
                        run_d = '0;
                    end

                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            run_q   <= '0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign hit       = hit_q;
    assign hit_count = cnt_q;

`ifdef ZERO_SCAN_IRQ_EN
    logic irq_q, irq_d;

    // Set during the done cycle so irq appears the cycle after; set beats clear.
    always_comb begin
        irq_d = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if ((state_q == DONE) && (cnt_q != '0)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
